// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that multiplexes N_SRC byte streams onto one uart_tx_buf write port.
// Packets are atomic, writes are paced by a credit counter, and a stall timeout recovers from dead sources.
module uart_tx_arbiter #(
    parameter int unsigned N_SRC   = 2,
    parameter int unsigned BURST   = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [8*N_SRC-1:0]   src_data,
    input  logic [N_SRC-1:0]     src_last,
    output logic [N_SRC-1:0]     src_ready,
    output logic                 tx_put,
    output logic [7:0]           tx_data,
    input  logic                 tx_empty,
    output logic [N_SRC-1:0]     grant,
    output logic                 abort
);

    localparam int unsigned PW = $clog2(N_SRC);
    localparam int unsigned CW = $clog2(BURST + 1);
    localparam int unsigned SW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, SETTLE, DRAIN} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   credits;
    logic [SW-1:0]   stall;
    logic            tx_put_q;

    logic [PW-1:0]   pick;
    logic            pick_ok;
    logic [PW-1:0]   gidx;
    logic [7:0]      lane;
    logic            valid_g;
    logic            last_g;
    logic            accept;

    // Rotating priority search: first requester strictly after ptr.
    always_comb begin
        logic [PW-1:0] cand;
        int unsigned   idx;
        pick    = '0;
        pick_ok = 1'b0;
        cand    = '0;
        idx     = 0;
        for (int unsigned i = 1; i <= N_SRC; i++) begin
            idx  = (32'(ptr) + i) % N_SRC;
            cand = PW'(idx);
            if (!pick_ok && src_valid[cand]) begin
                pick_ok = 1'b1;
                pick    = cand;
            end
        end
    end

    always_comb begin
        gidx = '0;
        lane = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                gidx = PW'(i);
                lane = src_data[8*i +: 8];
            end
        end
    end

    assign valid_g   = |(src_valid & grant);
    assign last_g    = |(src_last & grant);
    assign accept    = !rst && (state == SEND) && valid_g && (credits != '0);
    assign src_ready = accept ? grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            tx_put   <= 1'b0;
            tx_data  <= '0;
            abort    <= 1'b0;
            credits  <= CW'(BURST);
            ptr      <= PW'(N_SRC - 1);
            stall    <= '0;
            tx_put_q <= 1'b0;
        end else begin
            tx_put   <= 1'b0;
            abort    <= 1'b0;
            tx_put_q <= tx_put;
            case (state)
                IDLE: begin
                    // Buffer has been empty with no write in flight for two cycles: safe to refill credits.
                    if (tx_empty && !tx_put && !tx_put_q)
                        credits <= CW'(BURST);
                    if (pick_ok) begin
                        grant <= N_SRC'(1) << pick;
                        stall <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        tx_put  <= 1'b1;
                        tx_data <= lane;
                        credits <= credits - 1'b1;
                        stall   <= '0;
                        if (last_g) begin
                            ptr   <= gidx;
                            grant <= '0;
                            state <= (credits == CW'(1)) ? SETTLE : IDLE;
                        end else if (credits == CW'(1)) begin
                            state <= SETTLE;
                        end
                    end else if (!valid_g) begin
                        if (stall != '1)
                            stall <= stall + 1'b1;
                        if (TIMEOUT != 0 && (32'(stall) + 1) >= TIMEOUT) begin
                            grant <= '0;
                            ptr   <= gidx;
                            abort <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                SETTLE: state <= DRAIN;
                DRAIN: begin
                    if (tx_empty) begin
                        credits <= CW'(BURST);
                        state   <= (grant != '0) ? SEND : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two queued byte sources, a TX capture log and hand-computed expectations.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  src_valid;
    logic [15:0] src_data;
    logic [1:0]  src_last;
    logic [1:0]  src_ready;
    logic        tx_put;
    logic [7:0]  tx_data;
    logic        tx_empty;
    logic [1:0]  grant;
    logic        abort;

    uart_tx_arbiter #(.N_SRC(2), .BURST(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ready(src_ready),
        .tx_put(tx_put), .tx_data(tx_data), .tx_empty(tx_empty),
        .grant(grant), .abort(abort)
    );

    int vecs = 0;
    int errs = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] txq[$];
    int cyc = 0;
    int last_put_cyc = 0;
    int abort_cyc = 0;
    int abort_cnt = 0;
    int rdy0_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source model: bit 8 of each queue entry is the last flag; pop on a sampled ready.
    task automatic present();
        logic [8:0] e0, e1;
        e0 = (q0.size() > 0) ? q0[0] : 9'h000;
        e1 = (q1.size() > 0) ? q1[0] : 9'h000;
        src_valid = {q1.size() > 0, q0.size() > 0};
        src_data  = {e1[7:0], e0[7:0]};
        src_last  = {e1[8], e0[8]};
    endtask

    always begin
        @(posedge clk);
        if (src_ready[0] === 1'b1 && q0.size() > 0) void'(q0.pop_front());
        if (src_ready[1] === 1'b1 && q1.size() > 0) void'(q1.pop_front());
        #1 present();
        @(negedge clk);
        present();
    end

    always @(posedge clk) begin
        cyc++;
        if (tx_put === 1'b1) begin
            txq.push_back(tx_data);
            last_put_cyc = cyc;
        end
        if (abort === 1'b1) begin
            abort_cnt++;
            abort_cyc = cyc;
        end
        if (src_ready[0] === 1'b1) rdy0_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_txq(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && txq.size() < n; i++) step();
        chk(tag, txq.size(), n);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        step();
        step();
        rst = 1'b0;
        txq.delete();
        rdy0_cnt  = 0;
        abort_cnt = 0;
    endtask

    initial begin
        logic [7:0] exp2 [5];
        logic [7:0] exp3 [8];
        rst = 1'b1;
        tx_empty = 1'b1;
        src_valid = '0;
        src_data = '0;
        src_last = '0;
        step();

        // Reset values
        reset_dut();
        chk("rst_grant", grant, 2'b00);
        chk("rst_tx_put", tx_put, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_abort", abort, 1'b0);
        chk("rst_ready", src_ready, 2'b00);

        // Single-byte packet
        q0.push_back({1'b1, 8'h41});
        step();
        chk("single_grant", grant, 2'b01);
        chk("single_ready", src_ready, 2'b01);
        step();
        chk("single_put", tx_put, 1'b1);
        chk("single_data", tx_data, 8'h41);
        chk("single_release", grant, 2'b00);
        chk("single_ready_off", src_ready, 2'b00);
        step();
        chk("single_put_off", tx_put, 1'b0);
        chk("single_data_hold", tx_data, 8'h41);
        chk("single_ready_cnt", rdy0_cnt, 1);

        // Packet atomicity
        reset_dut();
        exp2 = '{8'h61, 8'h62, 8'h0A, 8'h24, 8'h20};
        q0.push_back({1'b0, 8'h61});
        q0.push_back({1'b0, 8'h62});
        q0.push_back({1'b1, 8'h0A});
        q1.push_back({1'b0, 8'h24});
        q1.push_back({1'b1, 8'h20});
        wait_txq("atomic_count", 5, 60);
        for (int k = 0; k < 5; k++) chk($sformatf("atomic_byte%0d", k), txq[k], exp2[k]);

        // Round-robin fairness
        reset_dut();
        exp3 = '{8'h30, 8'h50, 8'h31, 8'h51, 8'h32, 8'h52, 8'h33, 8'h53};
        for (int k = 0; k < 4; k++) begin
            q0.push_back({1'b1, 8'(8'h30 + k)});
            q1.push_back({1'b1, 8'(8'h50 + k)});
        end
        wait_txq("rr_count", 8, 100);
        for (int k = 0; k < 8; k++) chk($sformatf("rr_byte%0d", k), txq[k], exp3[k]);

        // Credit pacing with the buffer never draining
        reset_dut();
        tx_empty = 1'b0;
        for (int k = 0; k < 6; k++) q0.push_back({k == 5, 8'(8'h10 + k)});
        for (int k = 0; k < 20; k++) step();
        chk("pace_burst", txq.size(), 4);
        chk("pace_grant_held", grant, 2'b01);
        chk("pace_no_ready", src_ready, 2'b00);
        tx_empty = 1'b1;
        wait_txq("pace_rest", 6, 30);
        chk("pace_byte4", txq[4], 8'h14);
        chk("pace_byte5", txq[5], 8'h15);
        for (int k = 0; k < 4; k++) step();
        tx_empty = 1'b0;
        txq.delete();
        for (int k = 0; k < 5; k++) q0.push_back({k == 4, 8'(8'h20 + k)});
        for (int k = 0; k < 20; k++) step();
        chk("pace_reload_burst", txq.size(), 4);
        tx_empty = 1'b1;
        wait_txq("pace_reload_rest", 5, 30);

        // Stall timeout
        reset_dut();
        q0.push_back({1'b0, 8'h70});
        q0.push_back({1'b0, 8'h71});
        wait_txq("to_bytes", 2, 20);
        q1.push_back({1'b1, 8'h80});
        for (int k = 0; k < 40 && abort !== 1'b1; k++) step();
        chk("to_abort", abort, 1'b1);
        chk("to_grant_drop", grant, 2'b00);
        step();
        chk("to_next_grant", grant, 2'b10);
        chk("to_abort_pulse", abort, 1'b0);
        chk("to_delay", abort_cyc - last_put_cyc, 16);
        wait_txq("to_src1_bytes", 3, 20);
        chk("to_src1_byte", txq[2], 8'h80);
        chk("to_abort_cnt", abort_cnt, 1);

        // Reset in the middle of a packet (credits at 2)
        reset_dut();
        tx_empty = 1'b0;
        for (int k = 0; k < 5; k++) q0.push_back({k == 4, 8'(8'h90 + k)});
        step();
        step();
        step();
        chk("mid_put_before", tx_put, 1'b1);
        chk("mid_data_before", tx_data, 8'h91);
        rst = 1'b1;
        step();
        chk("mid_grant", grant, 2'b00);
        chk("mid_tx_put", tx_put, 1'b0);
        chk("mid_ready", src_ready, 2'b00);
        rst = 1'b0;
        q0.delete();
        txq.delete();
        for (int k = 0; k < 5; k++) q0.push_back({k == 4, 8'(8'hA0 + k)});
        q1.push_back({1'b1, 8'hB0});
        for (int k = 0; k < 20; k++) step();
        chk("mid_credits", txq.size(), 4);
        chk("mid_src0_first", txq[0], 8'hA0);
        chk("mid_byte3", txq[3], 8'hA3);
        tx_empty = 1'b1;
        wait_txq("mid_rest", 6, 40);
        chk("mid_byte4", txq[4], 8'hA4);
        chk("mid_src1_after", txq[5], 8'hB0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
